// File: rtl/instr_issue.sv
// ---------------------------------------------------------------------------
// instr_issue
//
// Purpose:
//   Upstream driver of the control decoder. Instruction bytes are buffered in
//   a small FIFO and issued one at a time on 'instruction'. After waiting out
//   the decoder's registered latency, the 14-bit 'signals' word is captured
//   and classified:
//     - normal: presented downstream with a valid/ready handshake
//     - halt:   the word {6'b0, 8'hF0}; once retired, issue stops until 'resume'
//     - illegal: the word 14'h3FFF; raises a sticky trap that only 'rst' clears
//
// Parameters:
//   DEPTH    FIFO entries (power of two, >= 2)
//   DEC_LAT  decoder latency in clk cycles (1..7)
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   in_valid/in_ready/in_instr  upstream byte handshake (in_ready = FIFO not full)
//   instruction               registered byte driven to the control decoder
//   signals                   decoder word {regdst,branch,memread,memwrite,
//                             alusrc,regwrite,opcode[7:0]}
//   out_valid/out_ready       downstream handshake for the captured word
//   out_ctrl, out_opcode      signals[13:8] and signals[7:0] of the captured word
//   halted, resume            halt status and one-cycle resume pulse
//   trap, trap_instr, trap_cause  sticky fault flag, offending byte and cause
//                             (01 illegal word, 10 opcode echo mismatch)
//
// Configuration macro:
//   ISSUE_ECHO_CHECK_EN  when defined, a non-illegal word whose opcode field
//                        differs from the issued byte also traps (cause 10).
// ---------------------------------------------------------------------------
module instr_issue #(
    parameter int DEPTH   = 4,
    parameter int DEC_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_instr,
    output logic [7:0]  instruction,
    input  logic [13:0] signals,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_ctrl,
    output logic [7:0]  out_opcode,
    output logic        halted,
    input  logic        resume,
    output logic        trap,
    output logic [7:0]  trap_instr,
    output logic [1:0]  trap_cause
);

    localparam int          AW           = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT     = (AW + 1)'(DEPTH);
    localparam logic [2:0]  LAT_INIT     = 3'(DEC_LAT);
    localparam logic [13:0] ILLEGAL_WORD = 14'h3FFF;
    localparam logic [13:0] HALT_WORD    = {6'b000000, 8'hF0};

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        CAPT,
        OUT,
        HALTED,
        TRAP
    } state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [2:0]      cnt;
    logic            push;
    logic            pop;

    assign in_ready = (count != FULL_CNT);
    assign push     = in_valid && in_ready;
    // Only an idle issue engine draws from the FIFO; every other state,
    // including HALTED and TRAP, leaves the buffered bytes untouched.
    assign pop      = (state == IDLE) && (count != '0);

    // FIFO storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_instr;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. A push and a
    // pop on the same edge leave the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Issue FSM. The byte driven to the decoder only changes on a pop, so
    // the decoder input stays stable through WAIT and CAPT. WAIT spends
    // exactly DEC_LAT cycles before CAPT samples the decoder word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            instruction <= '0;
            out_valid   <= 1'b0;
            out_ctrl    <= '0;
            out_opcode  <= '0;
            halted      <= 1'b0;
            trap        <= 1'b0;
            trap_instr  <= '0;
            trap_cause  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        instruction <= mem[rd_ptr];
                        cnt         <= LAT_INIT;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 3'd1) begin
                        state <= CAPT;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                CAPT: begin
                    // Illegal word takes priority over the echo comparison.
                    if (signals == ILLEGAL_WORD) begin
                        trap       <= 1'b1;
                        trap_cause <= 2'b01;
                        trap_instr <= instruction;
                        state      <= TRAP;
                    end
`ifdef ISSUE_ECHO_CHECK_EN
                    else if (signals[7:0] != instruction) begin
                        trap       <= 1'b1;
                        trap_cause <= 2'b10;
                        trap_instr <= instruction;
                        state      <= TRAP;
                    end
`endif
                    else begin
                        out_ctrl   <= signals[13:8];
                        out_opcode <= signals[7:0];
                        out_valid  <= 1'b1;
                        state      <= OUT;
                    end
                end
                OUT: begin
                    // out_valid is always high here, so out_ready alone
                    // completes the handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if ({out_ctrl, out_opcode} == HALT_WORD) begin
                            halted <= 1'b1;
                            state  <= HALTED;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                HALTED: begin
                    if (resume) begin
                        halted <= 1'b0;
                        state  <= IDLE;
                    end
                end
                TRAP: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_issue.sv
// ---------------------------------------------------------------------------
// tb_instr_issue
//
// Purpose:
//   Self-checking bench for instr_issue. A behavioural control decoder with
//   DEC_LAT registered stages answers the issued byte. Accepted bytes go into
//   an expected queue; every downstream handshake must deliver the decoder
//   word of the oldest outstanding byte, and a stalled word must stay put.
//   Directed scenarios cover reset, back-to-back issue, stalls, halt/resume,
//   FIFO full behaviour, illegal-word traps and opcode echo checking, plus a
//   randomized stream.
// ---------------------------------------------------------------------------
module tb_instr_issue;

    localparam int DEPTH   = 4;
    localparam int DEC_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_instr;
    logic [7:0]  instruction;
    logic [13:0] signals;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_ctrl;
    logic [7:0]  out_opcode;
    logic        halted;
    logic        resume;
    logic        trap;
    logic [7:0]  trap_instr;
    logic [1:0]  trap_cause;

    int          vectors = 0;
    int          fails   = 0;
    logic [7:0]  exp_q[$];
    logic        hold_pend = 1'b0;
    logic [13:0] hold_word = '0;
    logic        echo_fault = 1'b0;
    logic [13:0] pipe [DEC_LAT];

    instr_issue #(.DEPTH(DEPTH), .DEC_LAT(DEC_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .instruction(instruction),
        .signals    (signals),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_opcode (out_opcode),
        .halted     (halted),
        .resume     (resume),
        .trap       (trap),
        .trap_instr (trap_instr),
        .trap_cause (trap_cause)
    );

    always #5 clk = ~clk;

    // Reference decoder: byte 55 is illegal, F0 decodes to the halt word, and
    // the opcode field echoes the byte unless the echo fault is injected.
    function automatic logic [13:0] dec_word(input logic [7:0] b, input logic fault);
        logic [5:0] c;
        logic [7:0] op;
        op = b;
        case (b[7:4])
            4'h0:    c = 6'b000001;
            4'h8:    c = 6'b001010;
            4'hB:    c = 6'b000100;
            4'hF:    c = 6'b000000;
            default: c = b[5:0] ^ 6'h15;
        endcase
        if (fault && b == 8'h0C) op = 8'h0D;
        if (b == 8'h55) return 14'h3FFF;
        return {c, op};
    endfunction

    // Registered decoder pipeline of DEC_LAT stages.
    always @(posedge clk) begin
        pipe[0] <= dec_word(instruction, echo_fault);
        for (int i = 1; i < DEC_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign signals = pipe[DEC_LAT-1];

    function automatic logic [7:0] rand_legal();
        logic [7:0] b;
        do b = 8'($urandom); while (b == 8'h55 || b == 8'hF0);
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle of inputs, scoring the handshake that the coming edge
    // completes and checking that a stalled word is held unchanged.
    task automatic tick(input logic iv, input logic [7:0] ib, input logic ordy);
        logic [13:0] w;
        in_valid  = iv;
        in_instr  = ib;
        out_ready = ordy;
        if (hold_pend) begin
            vectors++;
            if (out_valid !== 1'b1 || {out_ctrl, out_opcode} !== hold_word) begin
                fails++;
                $display("[TB] FAIL hold: got valid=%b word=%h, expected valid=1 word=%h",
                         out_valid, {out_ctrl, out_opcode}, hold_word);
            end
        end
        if (iv && in_ready) exp_q.push_back(ib);
        if (out_valid && ordy) begin
            vectors++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL spurious_word: got %h, expected no word", {out_ctrl, out_opcode});
            end else begin
                w = dec_word(exp_q.pop_front(), echo_fault);
                if ({out_ctrl, out_opcode} !== w) begin
                    fails++;
                    $display("[TB] FAIL word: got %h, expected %h", {out_ctrl, out_opcode}, w);
                end
            end
        end
        hold_pend = out_valid && !ordy;
        hold_word = {out_ctrl, out_opcode};
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0; resume = 1'b0;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
        hold_pend = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int c = 0;
        while (!out_valid && c < budget) begin
            tick(1'b0, 8'h00, 1'b0);
            c++;
        end
        vectors++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL wait_valid: got out_valid=%b, expected 1 within %0d cycles", out_valid, budget);
        end
    endtask

    task automatic run_until_empty(input int budget, input int pct);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            tick(1'b0, 8'h00, ($urandom_range(0, 99) < pct));
            c++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: got %0d outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({instruction, out_valid, out_ctrl, out_opcode, halted, trap, trap_instr, trap_cause} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got instr=%h v=%b ctrl=%b op=%h h=%b t=%b ti=%h tc=%b, expected all zero",
                     instruction, out_valid, out_ctrl, out_opcode, halted, trap, trap_instr, trap_cause);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        do_reset();
        tick(1'b1, 8'h0C, 1'b1);
        tick(1'b1, 8'h0D, 1'b1);
        tick(1'b1, 8'h0E, 1'b1);
        // Two edges have passed since the first push; its pop is one edge
        // after that push, and the word appears DEC_LAT+1 edges after the pop.
        k = 2;
        while (!out_valid && k < 50) begin
            tick(1'b0, 8'h00, 1'b1);
            k++;
        end
        vectors++;
        if (k != DEC_LAT + 2) begin
            fails++;
            $display("[TB] FAIL first_latency: got %0d edges, expected %0d", k, DEC_LAT + 2);
        end
        vectors++;
        if (out_ctrl !== 6'b000001 || out_opcode !== 8'h0C) begin
            fails++;
            $display("[TB] FAIL first_word: got ctrl=%b op=%h, expected ctrl=000001 op=0C", out_ctrl, out_opcode);
        end
        run_until_empty(60, 100);
        vectors++;
        if (instruction !== 8'h0E) begin
            fails++;
            $display("[TB] FAIL last_issued: got %h, expected 0E", instruction);
        end
    endtask

    task automatic test_stall();
        tick(1'b1, 8'h80, 1'b0);
        tick(1'b1, 8'hB0, 1'b0);
        wait_valid(30);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 8'h00, 1'b0);
            vectors++;
            if (out_opcode !== 8'h80 || instruction !== 8'h80) begin
                fails++;
                $display("[TB] FAIL stall_hold: got op=%h instr=%h, expected op=80 instr=80", out_opcode, instruction);
            end
        end
        run_until_empty(60, 100);
        vectors++;
        if (out_ctrl !== 6'b000100 || out_opcode !== 8'hB0) begin
            fails++;
            $display("[TB] FAIL stall_second: got ctrl=%b op=%h, expected ctrl=000100 op=B0", out_ctrl, out_opcode);
        end
    endtask

    task automatic test_halt_and_full();
        int mc;
        tick(1'b1, 8'hF0, 1'b0);
        tick(1'b1, 8'h0C, 1'b0);
        wait_valid(30);
        tick(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 8'h00, 1'b1);
        vectors++;
        if (halted !== 1'b1 || out_valid !== 1'b0 || instruction !== 8'hF0) begin
            fails++;
            $display("[TB] FAIL halt_state: got h=%b v=%b instr=%h, expected h=1 v=0 instr=F0",
                     halted, out_valid, instruction);
        end
        // Only 0C is buffered; halted issue leaves the FIFO filling up.
        mc = 1;
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (in_ready !== (mc < DEPTH)) begin
                fails++;
                $display("[TB] FAIL fill_in_ready: got %b, expected %b at occupancy %0d", in_ready, (mc < DEPTH), mc);
            end
            if (in_ready) mc++;
            tick(1'b1, rand_legal(), 1'b0);
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL full_in_ready: got %b, expected 0", in_ready);
        end
        // resume outside the pulse window must not matter; pulse once.
        resume = 1'b1;
        tick(1'b0, 8'h00, 1'b0);
        resume = 1'b0;
        vectors++;
        if (halted !== 1'b0) begin
            fails++;
            $display("[TB] FAIL resume: got halted=%b, expected 0", halted);
        end
        // Keep pushing while draining so pushes meet pops near the full mark.
        for (int i = 0; i < 40; i++) tick(($urandom_range(0, 1) == 1), rand_legal(), 1'b1);
        run_until_empty(200, 60);
    endtask

    task automatic test_trap();
        int mc;
        do_reset();
        tick(1'b1, 8'h55, 1'b1);
        for (int i = 0; i < DEC_LAT + 8; i++) tick(1'b0, 8'h00, 1'b1);
        vectors++;
        if (trap !== 1'b1 || trap_cause !== 2'b01 || trap_instr !== 8'h55 || out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL trap_illegal: got t=%b tc=%b ti=%h v=%b, expected t=1 tc=01 ti=55 v=0",
                     trap, trap_cause, trap_instr, out_valid);
        end
        mc = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            vectors++;
            if (in_ready !== (mc < DEPTH)) begin
                fails++;
                $display("[TB] FAIL trap_fill: got in_ready=%b, expected %b at occupancy %0d", in_ready, (mc < DEPTH), mc);
            end
            if (in_ready) mc++;
            tick(1'b1, rand_legal(), 1'b1);
        end
        for (int i = 0; i < 6; i++) tick(1'b0, 8'h00, 1'b1);
        vectors++;
        if (instruction !== 8'h55 || out_valid !== 1'b0 || trap !== 1'b1) begin
            fails++;
            $display("[TB] FAIL trap_terminal: got instr=%h v=%b t=%b, expected instr=55 v=0 t=1",
                     instruction, out_valid, trap);
        end
        do_reset();
        vectors++;
        if (trap !== 1'b0 || trap_cause !== 2'b00 || trap_instr !== 8'h00 || in_ready !== 1'b1 || instruction !== 8'h00) begin
            fails++;
            $display("[TB] FAIL trap_reset: got t=%b tc=%b ti=%h rdy=%b instr=%h, expected t=0 tc=00 ti=00 rdy=1 instr=00",
                     trap, trap_cause, trap_instr, in_ready, instruction);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 1) == 1), rand_legal(), ($urandom_range(0, 99) < 70));
        end
        run_until_empty(600, 100);
    endtask

    task automatic test_echo();
        do_reset();
        echo_fault = 1'b1;
        tick(1'b1, 8'h0C, 1'b1);
        for (int i = 0; i < DEC_LAT + 8; i++) tick(1'b0, 8'h00, 1'b1);
`ifdef ISSUE_ECHO_CHECK_EN
        vectors++;
        if (trap !== 1'b1 || trap_cause !== 2'b10 || trap_instr !== 8'h0C || exp_q.size() != 1) begin
            fails++;
            $display("[TB] FAIL echo_trap: got t=%b tc=%b ti=%h pending=%0d, expected t=1 tc=10 ti=0C pending=1",
                     trap, trap_cause, trap_instr, exp_q.size());
        end
`else
        vectors++;
        if (trap !== 1'b0 || out_opcode !== 8'h0D || exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL echo_unchecked: got t=%b op=%h pending=%0d, expected t=0 op=0D pending=0",
                     trap, out_opcode, exp_q.size());
        end
`endif
        echo_fault = 1'b0;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_halt_and_full();
        test_trap();
        test_random();
        test_echo();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
